// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the uart_tx instance.
// The slave modport is the arbiter's view; master is the producer/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_active;
  logic                 tx_done;
  logic                 busy;
  logic [GID_W-1:0]     grant_id;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, tx_active, tx_done,
    output req_ack, tx_dv, tx_byte, busy, grant_id, timeout_err
  );

  modport master (
    output req_valid, req_data, tx_active, tx_done,
    input  req_ack, tx_dv, tx_byte, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte producers, one byte in flight
// at a time, with a per-byte completion watchdog and an optional post-byte idle gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 124992,
  parameter int GAP_CLKS     = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_tx_arbiter_if.slave io_bus
);

  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  localparam logic [GID_W:0]   NREQ_EXT = (GID_W + 1)'(NUM_REQ);
  localparam logic [GID_W-1:0] LAST_ID  = GID_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [GID_W-1:0]   r_rr_ptr;
  logic [GID_W-1:0]   r_grant_id;
  logic [7:0]         r_tx_byte;
  logic               r_tx_dv;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;
  logic               r_timeout;
  logic [WD_W-1:0]    r_wd;
  logic [GAP_W-1:0]   r_gap;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_any;
  logic [GID_W-1:0]     w_off;
  logic [GID_W:0]       w_sum;
  logic [GID_W-1:0]     w_win;
  logic [7:0]           w_byte;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [GID_W-1:0]     w_rr_next;

  // Rotate the request vector so bit 0 is the rr_ptr slot, find the first set bit,
  // then rotate the offset back into an absolute requester index.
  always_comb begin
    w_dbl = {io_bus.req_valid, io_bus.req_valid};
    w_rot = NUM_REQ'(w_dbl >> r_rr_ptr);
    w_any = 1'b0;
    w_off = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_any && w_rot[i]) begin
        w_any = 1'b1;
        w_off = GID_W'(i);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_win = (w_sum >= NREQ_EXT) ? GID_W'(w_sum - NREQ_EXT) : GID_W'(w_sum);

    w_byte       = '0;
    w_win_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == GID_W'(i)) begin
        w_byte          = io_bus.req_data[8*i +: 8];
        w_win_onehot[i] = 1'b1;
      end
    end

    w_rr_next = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_tx_byte  <= '0;
      r_tx_dv    <= 1'b0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_wd       <= '0;
      r_gap      <= '0;
    end else begin
      r_tx_dv   <= 1'b0;
      r_ack     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // tx_active also guards against a transmitter still busy after our own reset.
          if (w_any && !io_bus.tx_active) begin
            r_state    <= S_LAUNCH;
            r_grant_id <= w_win;
            r_tx_byte  <= w_byte;
            r_tx_dv    <= 1'b1;
            r_ack      <= w_win_onehot;
            r_busy     <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_rr_ptr <= w_rr_next;
          r_wd     <= '0;
          r_state  <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (io_bus.tx_done) begin
            if (GAP_CLKS > 0) begin
              r_state <= S_GAP;
              r_gap   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_wd == WD_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.req_ack     = r_ack;
  assign io_bus.tx_dv       = r_tx_dv;
  assign io_bus.tx_byte     = r_tx_byte;
  assign io_bus.busy        = r_busy;
  assign io_bus.grant_id    = r_grant_id;
  assign io_bus.timeout_err = r_timeout;

  a_ack_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_ack));
  a_dv_launch  : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                  (r_tx_dv == (r_state == S_LAUNCH)));
  a_ack_launch : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                  ((r_ack != '0) == (r_state == S_LAUNCH)));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx stand-in that pulses
// tx_done a fixed number of cycles after each tx_dv.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .TIMEOUT_CLKS(50),
    .GAP_CLKS    (2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: tx_done high m_done_at cycles after the tx_dv cycle.
  int   m_cnt      = 0;
  int   m_done_at  = 20;
  bit   m_suppress = 1'b0;
  bit   m_hold     = 1'b0;
  logic m_done     = 1'b0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_cnt != 0) begin
      if (m_cnt == m_done_at - 1) begin
        m_done <= !m_suppress;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (bus.tx_dv === 1'b1) begin
      m_cnt <= 1;
    end
  end

  assign bus.tx_done   = m_done;
  assign bus.tx_active = (m_cnt != 0) || m_hold;

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    m_hold        = 1'b0;
    m_suppress    = 1'b0;
    m_done_at     = 20;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle busy=%b expected 0 after 80 cycles", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_dv !== 1'b0) begin failures++; $display("FAIL rst_dv got=%b exp=0", bus.tx_dv); end
    checks++; if (bus.req_ack !== 4'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0000", bus.req_ack); end
    checks++; if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL rst_byte got=%h exp=00", bus.tx_byte); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL rst_gid got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL rst_terr got=%b exp=0", bus.timeout_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_data[7:0]   = 8'hEE;
    bus.req_data[23:16] = 8'h15;
    bus.req_valid       = 4'b0100;
    @(negedge clk);
    checks++; if (bus.tx_dv !== 1'b1) begin failures++; $display("FAIL single_dv got=%b exp=1", bus.tx_dv); end
    checks++; if (bus.tx_byte !== 8'h15) begin failures++; $display("FAIL single_byte got=%h exp=15", bus.tx_byte); end
    checks++; if (bus.req_ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", bus.req_ack); end
    checks++; if (bus.grant_id !== 2'd2) begin failures++; $display("FAIL single_gid got=%0d exp=2", bus.grant_id); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    bus.req_valid       = '0;
    bus.req_data[23:16] = 8'hFF;
    @(negedge clk);
    checks++; if (bus.tx_dv !== 1'b0) begin failures++; $display("FAIL single_dv_pulse got=%b exp=0", bus.tx_dv); end
    checks++; if (bus.req_ack !== 4'b0) begin failures++; $display("FAIL single_ack_pulse got=%b exp=0000", bus.req_ack); end
    repeat (21) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_gap_busy got=%b exp=1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_end_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_byte !== 8'h15) begin failures++; $display("FAIL single_byte_hold got=%h exp=15", bus.tx_byte); end
  endtask

  task automatic test_round_robin();
    int acks;
    do_reset();
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_valid = 4'b1111;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      int n;
      logic [7:0] exp_byte;
      logic [3:0] exp_ack;
      n = 0;
      exp_byte = 8'(8'hA0 + (k % 4));
      exp_ack  = 4'(1 << (k % 4));
      do begin
        @(negedge clk);
        n++;
        if (bus.req_ack !== 4'b0) acks++;
      end while (bus.tx_dv !== 1'b1 && n < 40);
      if (k == 4) bus.req_valid = '0;
      checks++; if (bus.tx_dv !== 1'b1) begin failures++; $display("FAIL rr_dv_%0d got=%b exp=1 within 40 cycles", k, bus.tx_dv); end
      checks++; if (bus.tx_byte !== exp_byte) begin failures++; $display("FAIL rr_byte_%0d got=%h exp=%h", k, bus.tx_byte, exp_byte); end
      checks++; if (bus.req_ack !== exp_ack) begin failures++; $display("FAIL rr_ack_%0d got=%b exp=%b", k, bus.req_ack, exp_ack); end
      checks++; if (bus.grant_id !== 2'(k % 4)) begin failures++; $display("FAIL rr_gid_%0d got=%0d exp=%0d", k, bus.grant_id, k % 4); end
    end
    repeat (30) begin
      @(negedge clk);
      if (bus.req_ack !== 4'b0) acks++;
    end
    checks++; if (acks != 5) begin failures++; $display("FAIL rr_ack_count got=%0d exp=5", acks); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    bus.req_data[31:24] = 8'h3C;
    bus.req_valid       = 4'b1000;
    @(negedge clk);
    checks++; if (bus.grant_id !== 2'd3 || bus.tx_dv !== 1'b1) begin failures++; $display("FAIL b2b_first gid=%0d dv=%b exp gid=3 dv=1", bus.grant_id, bus.tx_dv); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_dv !== 1'b1 && n < 40);
    bus.req_valid = '0;
    checks++; if (n != 24) begin failures++; $display("FAIL b2b_spacing got=%0d exp=24", n); end
    checks++; if (bus.grant_id !== 2'd3) begin failures++; $display("FAIL b2b_gid got=%0d exp=3", bus.grant_id); end
    wait_idle("b2b");
  endtask

  task automatic test_timeout();
    bit early;
    do_reset();
    m_suppress    = 1'b1;
    bus.req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    bus.req_valid = 4'b1001;
    @(negedge clk);
    checks++; if (bus.grant_id !== 2'd0 || bus.tx_dv !== 1'b1) begin failures++; $display("FAIL to_first gid=%0d dv=%b exp gid=0 dv=1", bus.grant_id, bus.tx_dv); end
    bus.req_valid = 4'b1000;
    early = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.timeout_err !== 1'b0 || bus.tx_dv !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin failures++; $display("FAIL to_early got=1 exp=0 (err or dv before 51 cycles)"); end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", bus.timeout_err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_pulse got=%b exp=0", bus.timeout_err); end
    checks++; if (bus.tx_dv !== 1'b1 || bus.grant_id !== 2'd3) begin failures++; $display("FAIL to_next dv=%b gid=%0d exp dv=1 gid=3", bus.tx_dv, bus.grant_id); end
    checks++; if (bus.tx_byte !== 8'h33 || bus.req_ack !== 4'b1000) begin failures++; $display("FAIL to_next_data byte=%h ack=%b exp 33 1000", bus.tx_byte, bus.req_ack); end
    bus.req_valid = '0;
    m_suppress    = 1'b0;
    wait_idle("to");
  endtask

  task automatic test_done_vs_timeout();
    bit   err_seen;
    logic b51, b53;
    do_reset();
    m_done_at           = 50;
    bus.req_data[15:8]  = 8'h42;
    bus.req_valid       = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    err_seen = 1'b0;
    b51 = 1'bx;
    b53 = 1'bx;
    for (int j = 1; j <= 55; j++) begin
      @(negedge clk);
      if (bus.timeout_err !== 1'b0) err_seen = 1'b1;
      if (j == 51) b51 = bus.busy;
      if (j == 53) b53 = bus.busy;
    end
    checks++; if (err_seen) begin failures++; $display("FAIL dvt_err got=1 exp=0"); end
    checks++; if (b51 !== 1'b1) begin failures++; $display("FAIL dvt_gap_busy got=%b exp=1", b51); end
    checks++; if (b53 !== 1'b0) begin failures++; $display("FAIL dvt_end_busy got=%b exp=0", b53); end
    m_done_at = 20;
  endtask

  task automatic test_reset_mid_byte();
    bit dv_seen;
    do_reset();
    bus.req_data[23:16] = 8'h55;
    bus.req_valid       = 4'b0100;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    m_hold = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.tx_dv !== 1'b0) begin failures++; $display("FAIL arst_ctl busy=%b dv=%b exp 0 0", bus.busy, bus.tx_dv); end
    checks++; if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL arst_byte got=%h exp=00", bus.tx_byte); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL arst_gid got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.req_ack !== 4'b0 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL arst_ack_err ack=%b err=%b exp 0000 0", bus.req_ack, bus.timeout_err); end
    bus.req_data[7:0] = 8'h11;
    bus.req_valid     = 4'b0001;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dv_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.tx_dv !== 1'b0 || bus.timeout_err !== 1'b0) dv_seen = 1'b1;
    end
    checks++; if (dv_seen) begin failures++; $display("FAIL arst_blocked got=1 exp=0 (dv/err while tx_active)"); end
    m_hold = 1'b0;
    @(negedge clk);
    checks++; if (bus.tx_dv !== 1'b1 || bus.req_ack !== 4'b0001) begin failures++; $display("FAIL arst_resume dv=%b ack=%b exp 1 0001", bus.tx_dv, bus.req_ack); end
    checks++; if (bus.tx_byte !== 8'h11) begin failures++; $display("FAIL arst_resume_byte got=%h exp=11", bus.tx_byte); end
    bus.req_valid = '0;
    wait_idle("arst");
  endtask

  task automatic test_withdrawal();
    bit activity;
    do_reset();
    bus.req_data[23:16] = 8'h66;
    bus.req_valid       = 4'b0100;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (21) @(negedge clk);
    bus.req_data[15:8] = 8'h77;
    bus.req_valid      = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    activity = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.tx_dv !== 1'b0 || bus.req_ack !== 4'b0) activity = 1'b1;
    end
    checks++; if (activity) begin failures++; $display("FAIL wd_no_grant got=1 exp=0 (dv/ack after withdrawal)"); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wd_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid_byte();
    test_withdrawal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached exp=finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter between NUM_REQ byte producers, e.g. adder result, receive echo and status reporter, using round-robin arbitration.
- Drives the transmitter's i_Tx_DV / i_Tx_Byte and sequences one byte at a time, waiting for o_Tx_Done before the next grant.
- Supervises each byte with a watchdog and enforces an optional inter-byte gap.
- Sits between the UART_Adder-level control FSMs and the uart_tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CLKS, 124992, max cycles in WAIT_DONE before abort (12 bit-times at CLKS_PER_BIT=10416).
- GAP_CLKS, 0, idle cycles inserted after each completed byte before the next grant.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte-pending flag; held high with stable data until acked.
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- tx_dv  out  1  to uart_tx i_Tx_DV; one-cycle start pulse.
- tx_byte  out  8  to uart_tx i_Tx_Byte; valid when tx_dv=1, held until next grant.
- tx_active  in  1  from uart_tx o_Tx_Active.
- tx_done  in  1  from uart_tx o_Tx_Done.
- busy  out  1  high in any state except IDLE.
- grant_id  out  clog2(NUM_REQ) (min 1)  index of last granted requester.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a byte.

Behaviour:
- Reset (async, Reset=0): state=IDLE; tx_dv=0, tx_byte=0, req_ack=0, grant_id=0, busy=0, timeout_err=0, rr_ptr=0, counters=0. Asserting reset mid-byte aborts it silently; no ack, no error.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE: if any req_valid=1 and tx_active=0, pick winner = first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ. Register winner, grant_id, tx_byte = req_data[winner] -> LAUNCH. If tx_active=1, stay in IDLE; this covers the transmitter still running after our own reset.
- LAUNCH (exactly 1 cycle): tx_dv=1, req_ack[winner]=1; rr_ptr <= (winner+1) mod NUM_REQ; clear watchdog -> WAIT_DONE.
- Latency: req_valid sampled high in IDLE at cycle N -> tx_dv and req_ack high at cycle N+1.
- A requester dropping req_valid before being sampled in IDLE is a legal withdrawal. Data sampled in IDLE is what is sent; later req_data changes are ignored.
- WAIT_DONE: watchdog increments each cycle.
  - tx_done=1 -> GAP if GAP_CLKS>0, else IDLE.
  - Watchdog reaches TIMEOUT_CLKS-1 with tx_done=0 -> timeout_err=1 for one cycle -> IDLE.
  - tx_done and timeout in the same cycle: tx_done wins, no error.
- GAP: counts GAP_CLKS cycles (0..GAP_CLKS-1) -> IDLE. Requests are not evaluated in GAP.
- req_ack and tx_dv are never high outside LAUNCH. At most one req_ack bit is set at any time.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0,... A lone requester is served back-to-back.
- tx_done seen in IDLE/LAUNCH/GAP is ignored.
- Counter widths: clog2(TIMEOUT_CLKS) and clog2(GAP_CLKS+1), minimum 1 bit; no wrap inside a byte.

Test Plan:
Bench uses NUM_REQ=4, TIMEOUT_CLKS=50, GAP_CLKS=2, plus a uart_tx model asserting tx_done 20 cycles after tx_dv.
1. Single request: req_valid=4'b0100, req_data[23:16]=8'h15 -> next cycle tx_dv=1, tx_byte=8'h15, req_ack=4'b0100, grant_id=2; tx_done 20 cycles later; 2 GAP cycles; busy=0 afterwards.
2. All four valid continuously with data 8'hA0..8'hA3 -> tx_byte sequence A0,A1,A2,A3,A0; each req_ack pulse exactly once per byte.
3. Timeout: model never asserts tx_done -> timeout_err pulse 50 cycles after the LAUNCH cycle; state IDLE; pending requester 3 granted next.
4. tx_done and the last timeout cycle coincide -> timeout_err stays 0; normal completion.
5. Reset=0 held 3 cycles mid WAIT_DONE while tx_active=1 -> all outputs 0 immediately (asynchronous); after release, no tx_dv until tx_active falls even with req_valid=4'b0001.
6. Withdrawal: req_valid[1] pulses high for one cycle during GAP -> no ack for requester 1; tx_dv stays 0.
